dbus_down_seq: RTL and testbench
================================

Name: dbus_down_seq

Overview:
- Beat sequencer for the 64-to-32 down-mux in the data bus path.
- Takes one 64-bit phrase transaction: start byte offset, transfer size, destination port width.
- Splits it into narrow beats and drives the mux select `dmuxd[2:0]` once per beat.
- Uses a valid/ready handshake with the narrow destination.
- Sits beside the down-mux in the bus interface, between the phrase source and byte/word/long consumers.

Parameters:
none

Ports:
sys_clk     in   1  system clock
resetl      in   1  asynchronous active-low reset
start       in   1  transaction request; accepted only when busy=0
tsize       in   2  00 byte, 01 word, 10 long, 11 phrase
taddr       in   3  byte offset within phrase; low bits below tsize alignment ignored
pwidth      in   2  destination width: 00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 32-bit
abort       in   1  synchronous cancel of the current transaction
bready      in   1  destination accepts current beat
dmuxd       out  3  down-mux select for current beat
bvalid      out  1  current beat valid
blast       out  1  current beat is final beat
beat_addr   out  3  byte offset of current beat
busy        out  1  transaction in progress
done        out  1  one-cycle pulse after final beat accepted

Behaviour:
- Clocking and reset:
  - Reset is asynchronous and active-low; one clock.
  - All outputs registered.
  - Reset values: dmuxd=000, bvalid=0, blast=0, beat_addr=000, busy=0, done=0, FSM=IDLE.
- Sizes:
  - Transfer bytes S = 1/2/4/8 for tsize 00/01/10/11.
  - Port bytes P = 1/2/4.
  - Beat width W = min(S, P).
  - Beat count N = S/W, range 1..8.
- Addressing:
  - Base offset A = taddr with its low log2(S) bits cleared.
  - Beat i offset O_i = A + i*W, modulo 8 (cannot wrap for legal combinations).
- Select mapping:
  - W=4: dmuxd = {O[2],0,0}.
  - W=2: dmuxd = {O[2],O[1],0}.
  - W=1: dmuxd = O[2:0].
  - Result: the selected byte/word/long appears in the low lanes of the down-mux output.
- IDLE state:
  - Outputs idle: bvalid=0, dmuxd=000.
  - start=1 and abort=0 at edge N: latch W, N and A. At N+1, FSM=XFER with busy=1, bvalid=1, dmuxd/beat_addr for beat 0, blast=(N==1).
  - start and abort together in IDLE: start ignored.
- XFER state:
  - bvalid held 1 with dmuxd, beat_addr and blast stable until bvalid&bready.
  - On handshake of a non-final beat: next cycle presents beat i+1.
  - On handshake of the final beat: next cycle FSM=IDLE, busy=0, bvalid=0, dmuxd=000, done=1 for exactly one cycle.
  - No gap cycles: with bready held 1, one beat per cycle.
- start while busy: ignored, not queued.
- A start arriving in the same cycle done is asserted is accepted, since FSM is IDLE then. Back-to-back throughput is N beats plus 1 idle cycle.
- abort in XFER, including in the same cycle as a handshake: next cycle IDLE, idle outputs, done stays 0.
- The phrase source holds din stable while busy=1; this block does not latch data.
- Async reset mid-transfer: outputs go to reset values immediately; no done.

Decomposition:
- Shared package holds:
  - TSIZE_BYTE/WORD/LONG/PHRASE (2-bit) and PW_8/16/32.
  - FSM state enum IDLE/XFER.
  - function sel_of(offset[2:0], width_code) returning dmuxd.
- One natural sub-module, dbus_beat_calc: combinational.
  - Inputs: tsize, taddr, pwidth.
  - Outputs: W code, N-1 (3 bits), aligned base A.
  - Lets the bench check it standalone.
- FSM, beat counter and offset accumulator live in dbus_down_seq.

Test Plan:
1. Long, 32-bit port: tsize=10, taddr=100, pwidth=10, bready=1 → one beat with dmuxd=100, beat_addr=100, blast=1; done=1 the following cycle.
2. Phrase, 8-bit port: tsize=11, taddr=000, pwidth=00, bready=1 → 8 consecutive beats with dmuxd/beat_addr 000..111; blast on 8th; done one cycle later; busy high exactly 8 cycles.
3. Phrase, 16-bit port with stalls: bready=0 for 2 cycles on beat 1 → beats 000,010,100,110; dmuxd=010 held 3 cycles; 4 handshakes total.
4. Misaligned word, 8-bit port: tsize=01, taddr=011, pwidth=00 → aligned base 010; beats dmuxd=010 then 011; blast on second.
5. Abort mid-phrase: 8-bit port, abort during beat 3 → next cycle busy=0, bvalid=0, dmuxd=000, done never asserted. A start 1 cycle later begins a fresh beat 0.
6. Reset and start collisions:
   - resetl low mid-transfer (beat 2) → outputs zero asynchronously.
   - After release, start accepted normally.
   - start during busy ignored.
   - start in the done cycle accepted.

Source files
------------

// File: rtl/dbus_down_seq_pkg.sv
// Shared encodings for the 64-to-32 down-mux beat sequencer.
// Combinational helper only; no state.
// No flow control here; the sequencer owns the handshake.
package dbus_down_seq_pkg;

  // Transfer size codes; the numeric value is log2 of the byte count
  localparam logic [1:0] TSIZE_BYTE   = 2'b00;
  localparam logic [1:0] TSIZE_WORD   = 2'b01;
  localparam logic [1:0] TSIZE_LONG   = 2'b10;
  localparam logic [1:0] TSIZE_PHRASE = 2'b11;

  // Destination port width codes; code 2'b11 is folded onto PW_32
  localparam logic [1:0] PW_8  = 2'b00;
  localparam logic [1:0] PW_16 = 2'b01;
  localparam logic [1:0] PW_32 = 2'b10;

  // Beat width codes, log2 of the beat byte count
  localparam logic [1:0] WC_1 = 2'b00;
  localparam logic [1:0] WC_2 = 2'b01;
  localparam logic [1:0] WC_4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Mux select for a beat: drop the offset bits below the beat width so the
  // chosen byte/word/long lands in the low lanes of the down-mux
  function automatic logic [2:0] sel_of(input logic [2:0] offset,
                                        input logic [1:0] width_code);
    logic [2:0] sel;
    case (width_code)
      WC_4:    sel = {offset[2], 2'b00};
      WC_2:    sel = {offset[2:1], 1'b0};
      default: sel = offset;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dbus_beat_calc.sv
// Beat geometry for one phrase transaction: beat width, beat count - 1, aligned base.
// Latency: purely combinational.
// No flow control; outputs track inputs.
module dbus_beat_calc
  import dbus_down_seq_pkg::*;
(
  input  logic [1:0] i_tsize,
  input  logic [2:0] i_taddr,
  input  logic [1:0] i_pwidth,
  output logic [1:0] o_wcode,
  output logic [2:0] o_nm1,
  output logic [2:0] o_base
);

  logic [1:0] w_pcode;
  logic [1:0] w_wcode;
  logic [1:0] w_shift;

  // Beat width is the smaller of transfer size and port width; beats = S/W
  always_comb begin
    w_pcode = (i_pwidth == 2'b11) ? PW_32 : i_pwidth;
    w_wcode = (i_tsize < w_pcode) ? i_tsize : w_pcode;
    w_shift = i_tsize - w_wcode;
    o_wcode = w_wcode;
    case (w_shift)
      2'd0:    o_nm1 = 3'd0;
      2'd1:    o_nm1 = 3'd1;
      2'd2:    o_nm1 = 3'd3;
      default: o_nm1 = 3'd7;
    endcase
    case (i_tsize)
      TSIZE_BYTE: o_base = i_taddr;
      TSIZE_WORD: o_base = {i_taddr[2:1], 1'b0};
      TSIZE_LONG: o_base = {i_taddr[2], 2'b00};
      default:    o_base = 3'b000;
    endcase
  end

endmodule

// File: rtl/dbus_down_seq.sv
// Splits one 64-bit phrase transaction into narrow beats and drives the down-mux select.
// Latency: first beat one cycle after start; one beat per cycle; done one cycle after last beat.
// Beat outputs hold while bready is low; start is ignored while busy; abort cancels without done.
module dbus_down_seq
  import dbus_down_seq_pkg::*;
(
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic       start,
  input  logic [1:0] tsize,
  input  logic [2:0] taddr,
  input  logic [1:0] pwidth,
  input  logic       abort,
  input  logic       bready,
  output logic [2:0] dmuxd,
  output logic       bvalid,
  output logic       blast,
  output logic [2:0] beat_addr,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  logic [1:0] r_wcode;
  logic [2:0] r_nm1;
  logic [2:0] r_idx;
  logic [2:0] r_addr;
  logic [2:0] r_dmuxd;
  logic       r_bvalid;
  logic       r_blast;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_wcode;
  logic [2:0] w_nm1;
  logic [2:0] w_base;
  logic [2:0] w_step;
  logic [2:0] w_next_addr;
  logic [2:0] w_next_idx;

  dbus_beat_calc u_calc (
    .i_tsize  (tsize),
    .i_taddr  (taddr),
    .i_pwidth (pwidth),
    .o_wcode  (w_wcode),
    .o_nm1    (w_nm1),
    .o_base   (w_base)
  );

  // Offset of the following beat; legal geometries never wrap past byte 7
  assign w_step      = 3'd1 << r_wcode;
  assign w_next_addr = r_addr + w_step;
  assign w_next_idx  = r_idx + 3'd1;

  // Transaction FSM with beat counter, offset accumulator and registered beat outputs
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state  <= IDLE;
      r_wcode  <= WC_1;
      r_nm1    <= 3'd0;
      r_idx    <= 3'd0;
      r_addr   <= 3'd0;
      r_dmuxd  <= 3'd0;
      r_bvalid <= 1'b0;
      r_blast  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start && !abort) begin
          r_state  <= XFER;
          r_wcode  <= w_wcode;
          r_nm1    <= w_nm1;
          r_idx    <= 3'd0;
          r_addr   <= w_base;
          r_dmuxd  <= sel_of(w_base, w_wcode);
          r_bvalid <= 1'b1;
          r_blast  <= (w_nm1 == 3'd0);
          r_busy   <= 1'b1;
        end
      end else begin
        if (abort || (r_bvalid && bready && r_blast)) begin
          // Abort wins over a same-cycle final handshake, so no done then
          r_state  <= IDLE;
          r_idx    <= 3'd0;
          r_addr   <= 3'd0;
          r_dmuxd  <= 3'd0;
          r_bvalid <= 1'b0;
          r_blast  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= !abort;
        end else if (r_bvalid && bready) begin
          r_idx   <= w_next_idx;
          r_addr  <= w_next_addr;
          r_dmuxd <= sel_of(w_next_addr, r_wcode);
          r_blast <= (w_next_idx == r_nm1);
        end
      end
    end
  end

  assign dmuxd     = r_dmuxd;
  assign bvalid    = r_bvalid;
  assign blast     = r_blast;
  assign beat_addr = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_dbus_down_seq.sv
// Self-checking bench for dbus_down_seq: queue-based beat model plus directed literal checks.
// Inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
// Covers stalls, abort, async reset, start collisions and standalone beat geometry.
module tb_dbus_down_seq;

  logic       sys_clk = 1'b0;
  logic       resetl  = 1'b1;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic       bready  = 1'b0;
  logic [1:0] tsize   = 2'b00;
  logic [2:0] taddr   = 3'b000;
  logic [1:0] pwidth  = 2'b00;
  logic [2:0] dmuxd;
  logic       bvalid;
  logic       blast;
  logic [2:0] beat_addr;
  logic       busy;
  logic       done;

  logic [1:0] bc_tsize  = 2'b00;
  logic [2:0] bc_taddr  = 3'b000;
  logic [1:0] bc_pwidth = 2'b00;
  logic [1:0] bc_wcode;
  logic [2:0] bc_nm1;
  logic [2:0] bc_base;

  int tests = 0;
  int fails = 0;
  int hs    = 0;

  dbus_down_seq dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .start     (start),
    .tsize     (tsize),
    .taddr     (taddr),
    .pwidth    (pwidth),
    .abort     (abort),
    .bready    (bready),
    .dmuxd     (dmuxd),
    .bvalid    (bvalid),
    .blast     (blast),
    .beat_addr (beat_addr),
    .busy      (busy),
    .done      (done)
  );

  dbus_beat_calc u_bc (
    .i_tsize  (bc_tsize),
    .i_taddr  (bc_taddr),
    .i_pwidth (bc_pwidth),
    .o_wcode  (bc_wcode),
    .o_nm1    (bc_nm1),
    .o_base   (bc_base)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Model: queue of byte offsets of beats still to be delivered
  int q[$];
  int m_w    = 1;
  bit m_done = 1'b0;

  always @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() == 0) begin
        if (start && !abort) begin
          int s, p, a, n;
          s = 1 << tsize;
          p = (pwidth == 2'b00) ? 1 : (pwidth == 2'b01) ? 2 : 4;
          m_w = (s < p) ? s : p;
          n = s / m_w;
          a = taddr - (taddr % s);
          for (int i = 0; i < n; i++) q.push_back((a + i * m_w) % 8);
        end
      end else if (abort) begin
        q.delete();
      end else if (bready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end
  end

  // Handshake counter used by the stall test
  always @(posedge sys_clk) begin
    if (resetl && bvalid === 1'b1 && bready) hs++;
  end

  // Per-cycle compare against the model
  always @(negedge sys_clk) begin
    bit v;
    int off;
    v   = (q.size() > 0);
    off = v ? q[0] : 0;
    chk("m_bvalid", bvalid, v);
    chk("m_busy", busy, v);
    chk("m_beat_addr", beat_addr, off);
    chk("m_dmuxd", dmuxd, v ? (off - off % m_w) : 0);
    chk("m_blast", blast, q.size() == 1);
    chk("m_done", done, m_done);
  end

  initial begin
    int busy_cnt;
    int hs0;

    #1 resetl = 1'b0;
    // Standalone geometry checks
    bc_tsize = 2'b01; bc_taddr = 3'b011; bc_pwidth = 2'b00; #1;
    chk("bc_w0", bc_wcode, 0); chk("bc_n0", bc_nm1, 1); chk("bc_a0", bc_base, 2);
    bc_tsize = 2'b11; bc_taddr = 3'b101; bc_pwidth = 2'b01; #1;
    chk("bc_w1", bc_wcode, 1); chk("bc_n1", bc_nm1, 3); chk("bc_a1", bc_base, 0);
    bc_tsize = 2'b10; bc_taddr = 3'b110; bc_pwidth = 2'b11; #1;
    chk("bc_w2", bc_wcode, 2); chk("bc_n2", bc_nm1, 0); chk("bc_a2", bc_base, 4);
    bc_tsize = 2'b00; bc_taddr = 3'b111; bc_pwidth = 2'b10; #1;
    chk("bc_w3", bc_wcode, 0); chk("bc_n3", bc_nm1, 0); chk("bc_a3", bc_base, 7);

    chk("rst_bvalid", bvalid, 0); chk("rst_dmuxd", dmuxd, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_blast", blast, 0); chk("rst_addr", beat_addr, 0);
    repeat (2) @(posedge sys_clk);
    #3 resetl = 1'b1;
    step();

    // 1: long on 32-bit port, single beat
    tsize = 2'b10; taddr = 3'b100; pwidth = 2'b10; bready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk("t1_dmuxd", dmuxd, 3'b100); chk("t1_addr", beat_addr, 3'b100);
    chk("t1_blast", blast, 1); chk("t1_bvalid", bvalid, 1);
    step();
    chk("t1_done", done, 1); chk("t1_idle", bvalid, 0);
    step();
    chk("t1_done_pulse", done, 0);

    // 2: phrase on 8-bit port, eight back-to-back beats
    tsize = 2'b11; taddr = 3'b000; pwidth = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_addr", beat_addr, i);
      chk("t2_dmuxd", dmuxd, i);
      chk("t2_blast", blast, i == 7);
      if (busy) busy_cnt++;
      step();
    end
    chk("t2_done", done, 1); chk("t2_busy_off", busy, 0);
    chk("t2_busy_cnt", busy_cnt, 8);
    step();

    // 3: phrase on 16-bit port with a two-cycle stall on beat 1
    hs0 = hs;
    tsize = 2'b11; taddr = 3'b000; pwidth = 2'b01; start = 1'b1;
    step(); start = 1'b0;
    chk("t3_b0", dmuxd, 3'b000);
    step(); chk("t3_b1a", dmuxd, 3'b010); bready = 1'b0;
    step(); chk("t3_b1b", dmuxd, 3'b010);
    step(); chk("t3_b1c", dmuxd, 3'b010); bready = 1'b1;
    step(); chk("t3_b2", dmuxd, 3'b100);
    step(); chk("t3_b3", dmuxd, 3'b110); chk("t3_blast", blast, 1);
    step(); chk("t3_done", done, 1);
    chk("t3_hs", hs - hs0, 4);
    step();

    // 4: misaligned word on 8-bit port
    tsize = 2'b01; taddr = 3'b011; pwidth = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    chk("t4_b0", dmuxd, 3'b010); chk("t4_b0_last", blast, 0);
    step(); chk("t4_b1", dmuxd, 3'b011); chk("t4_b1_last", blast, 1);
    step(); chk("t4_done", done, 1);
    step();

    // 5: abort during beat 3 of a phrase, then a fresh start
    tsize = 2'b11; taddr = 3'b000; pwidth = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    repeat (3) step();
    chk("t5_beat3", beat_addr, 3);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t5_busy", busy, 0); chk("t5_bvalid", bvalid, 0);
    chk("t5_dmuxd", dmuxd, 0); chk("t5_done", done, 0);
    step(); chk("t5_done_late", done, 0);
    start = 1'b1;
    step(); start = 1'b0;
    chk("t5_restart_addr", beat_addr, 0); chk("t5_restart_vld", bvalid, 1);
    repeat (8) step();
    chk("t5_restart_done", done, 1);
    step();

    // 6: async reset mid-transfer, then start collisions
    tsize = 2'b11; taddr = 3'b000; pwidth = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    repeat (2) step();
    chk("t6_beat2", beat_addr, 2);
    #2 resetl = 1'b0;
    #1;
    chk("t6_rst_bvalid", bvalid, 0); chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", beat_addr, 0); chk("t6_rst_dmuxd", dmuxd, 0);
    chk("t6_rst_done", done, 0);
    @(posedge sys_clk); #3 resetl = 1'b1;
    step();
    tsize = 2'b10; taddr = 3'b000; pwidth = 2'b00; start = 1'b1;
    step(); start = 1'b0;
    chk("t6_post_vld", bvalid, 1); chk("t6_post_addr", beat_addr, 0);
    step();
    tsize = 2'b00; taddr = 3'b111; start = 1'b1;
    step(); start = 1'b0;
    chk("t6_busy_start", beat_addr, 2);
    step();
    chk("t6_last", beat_addr, 3); chk("t6_blast", blast, 1);
    tsize = 2'b00; taddr = 3'b101; pwidth = 2'b10; start = 1'b1;
    step();
    chk("t6_done", done, 1);
    step(); start = 1'b0;
    chk("t6_dc_vld", bvalid, 1); chk("t6_dc_addr", beat_addr, 5);
    chk("t6_dc_dmuxd", dmuxd, 5); chk("t6_dc_blast", blast, 1);
    step();
    chk("t6_dc_done", done, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
